// File: rtl/shift_feeder.sv
// Shift request feeder: buffers {operand, amount, tag} requests and sequences them one at a time
// through an external pipelined Shifter. Optional macro SHIFT_ZERO_BYPASS_EN returns zero-amount requests directly.
module shift_feeder #(
    parameter int SHIFT_LAT  = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [4:0]  in_amt,
    input  logic [2:0]  in_tag,
    output logic [15:0] sh_a,
    output logic [4:0]  sh_amt,
    input  logic [15:0] sh_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_r,
    output logic [2:0]  out_tag,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: a beat transfers on a rising edge where valid and ready are both 1; valid, once
    // raised, holds its payload stable until accepted; ready never depends combinationally on valid.

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = (SHIFT_LAT > 1) ? $clog2(SHIFT_LAT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(SHIFT_LAT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [23:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [WW-1:0] wcnt;
    logic [2:0]    fl_tag;
    logic          full, empty, push, pop, take, head_zero;
    logic          load_sh, load_byp, capture;
    logic [15:0]   head_a;
    logic [4:0]    head_amt;
    logic [2:0]    head_tag;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    // Held low while reset is asserted so nothing is offered to an upstream that is still running.
    assign in_ready  = reset_n & ~full;
    assign push      = in_valid & in_ready;
    assign busy      = (state_q != S_IDLE) | ~empty;
    assign dbg_state = state_q;

    assign {head_tag, head_amt, head_a} = mem[rd_ptr];

`ifdef SHIFT_ZERO_BYPASS_EN
    assign head_zero = (head_amt == 5'd0);
`else
    assign head_zero = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        pop      = 1'b0;
        load_sh  = 1'b0;
        load_byp = 1'b0;
        capture  = 1'b0;
        case (state_q)
            S_IDLE:  take = ~empty;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (wcnt == WAIT_LAST) begin
                    capture = 1'b1;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    take    = ~empty;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Taking the head either starts a Shifter pass or, for a bypassed zero shift, lands straight in OUT.
        if (take) begin
            pop = 1'b1;
            if (head_zero) begin
                load_byp = 1'b1;
                state_d  = S_OUT;
            end else begin
                load_sh = 1'b1;
                state_d = S_ISSUE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wcnt      <= '0;
            sh_a      <= '0;
            sh_amt    <= '0;
            fl_tag    <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_tag   <= '0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            wcnt  <= (state_q == S_WAIT) ? wcnt + WW'(1) : '0;
            if (load_sh) begin
                sh_a   <= head_a;
                sh_amt <= head_amt;
                fl_tag <= head_tag;
            end
            if (capture) begin
                out_r   <= sh_r;
                out_tag <= fl_tag;
            end else if (load_byp) begin
                out_r   <= head_a;
                out_tag <= head_tag;
            end
            out_valid <= (state_d == S_OUT);
        end
    end

    // Storage needs no reset: entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_tag, in_amt, in_a};
    end

endmodule

// File: tb/tb_shift_feeder.sv
// Bench for shift_feeder: table-driven single requests, a streamed burst, backpressure fill/drain
// and a reset during WAIT, with a behavioural Shifter model driving sh_r.
module tb_shift_feeder;

    localparam int LAT = 1;

    typedef struct {
        logic [15:0] a;
        logic [4:0]  amt;
        logic [2:0]  tag;
        logic [15:0] exp_r;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [4:0]  in_amt;
    logic [2:0]  in_tag;
    logic [15:0] sh_a;
    logic [4:0]  sh_amt;
    logic [15:0] sh_r;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_r;
    logic [2:0]  out_tag;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [18:0] exp_q[$];
    vec_t sv[6];
    vec_t sq[7];

    always #5 clk = ~clk;

    shift_feeder #(.SHIFT_LAT(LAT), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_amt(in_amt), .in_tag(in_tag), .sh_a(sh_a), .sh_amt(sh_amt),
        .sh_r(sh_r), .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
        .out_tag(out_tag), .busy(busy), .dbg_state(dbg_state)
    );

    function automatic logic [15:0] shift_ref(input logic [15:0] a, input logic [4:0] amt);
        logic [4:0] mag;
        if (amt[4]) begin
            mag = ~amt + 5'd1;
            return a >> mag;
        end
        return a << amt;
    endfunction

    logic [15:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= shift_ref(sh_a, sh_amt);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sh_r = pipe[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; returns at a negedge with the block idle.
    task automatic run_single(input vec_t v, input int id);
        logic [15:0] prev;
        int lat;
        int cyc;
        prev = sh_a;
        check($sformatf("single%0d_in_ready", id), 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_a = v.a; in_amt = v.amt; in_tag = v.tag;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("single%0d_latency", id), 32'(lat), 32'(v.exp_lat));
        check($sformatf("single%0d_out_r", id), 32'(out_r), 32'(v.exp_r));
        check($sformatf("single%0d_out_tag", id), 32'(out_tag), 32'(v.tag));
`ifdef SHIFT_ZERO_BYPASS_EN
        check($sformatf("single%0d_sh_a", id), 32'(sh_a), (v.amt == 5'd0) ? 32'(prev) : 32'(v.a));
`else
        check($sformatf("single%0d_sh_a", id), 32'(sh_a), 32'(v.a));
`endif
        cyc = 0;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("single%0d_idle", id), 32'(busy), 32'd0);
    endtask

    // Caller is at a negedge with out_ready set; pushes sq[first..first+n-1] and drains exp_q.
    task automatic run_stream(input int first, input int n, input string tag);
        int idx;
        int cyc;
        logic [18:0] e;
        idx = 0;
        cyc = 0;
        while ((idx < n || exp_q.size() > 0) && cyc < 200) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_unexpected"}, 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_out_r"}, 32'(out_r), 32'(e[15:0]));
                    check({tag, "_out_tag"}, 32'(out_tag), 32'(e[18:16]));
                end
            end
            if (idx < n && in_ready) begin
                in_valid = 1'b1;
                in_a = sq[first+idx].a; in_amt = sq[first+idx].amt; in_tag = sq[first+idx].tag;
                exp_q.push_back({sq[first+idx].tag, sq[first+idx].exp_r});
                idx++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic seen;
        reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_amt = '0; in_tag = '0; out_ready = 1'b1;

        sv[0] = '{16'd128,    5'd1,     3'd3, 16'd256,    3};
`ifdef SHIFT_ZERO_BYPASS_EN
        sv[1] = '{16'h1234,   5'd0,     3'd5, 16'h1234,   1};
`else
        sv[1] = '{16'h1234,   5'd0,     3'd5, 16'h1234,   3};
`endif
        sv[2] = '{16'h8001,   5'd15,    3'd1, 16'h8000,   3};
        sv[3] = '{16'hFFFF,   5'b10000, 3'd7, 16'h0000,   3};
        sv[4] = '{16'h00F0,   5'b11100, 3'd2, 16'h000F,   3};
        sv[5] = '{16'h0001,   5'b11111, 3'd0, 16'h0000,   3};

        sq[0] = '{16'd100,    5'd4,     3'd1, 16'd1600,   0};
        sq[1] = '{16'd10000,  5'b11111, 3'd2, 16'd5000,   0};
        sq[2] = '{16'd10000,  5'b11110, 3'd5, 16'd2500,   0};
        sq[3] = '{16'd3,      5'd2,     3'd1, 16'd12,     0};
        sq[4] = '{16'h8000,   5'b10001, 3'd2, 16'h0001,   0};
        sq[5] = '{16'h00FF,   5'd8,     3'd4, 16'hFF00,   0};
        sq[6] = '{16'h5555,   5'd1,     3'd6, 16'hAAAA,   0};

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_sh_a", 32'(sh_a), 32'd0);
        check("rst_out_r", 32'(out_r), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        reset_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_single(sv[i], i);

        out_ready = 1'b1;
        run_stream(0, 3, "stream");

        // Backpressure: one request in flight plus two buffered, the fourth refused.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_in_ready_%0d", i), 32'(in_ready), (i < 3) ? 32'd1 : 32'd0);
            in_valid = 1'b1; in_a = sq[3+i].a; in_amt = sq[3+i].amt; in_tag = sq[3+i].tag;
            if (i < 3) exp_q.push_back({sq[3+i].tag, sq[3+i].exp_r});
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_full_hold", 32'(in_ready), 32'd0);
        repeat (4) @(negedge clk);
        check("bp_held_valid", 32'(out_valid), 32'd1);
        check("bp_held_r", 32'(out_r), 32'd12);
        @(negedge clk);
        check("bp_stable_valid", 32'(out_valid), 32'd1);
        check("bp_stable_r", 32'(out_r), 32'd12);
        check("bp_stable_tag", 32'(out_tag), 32'd1);
        out_ready = 1'b1;
        run_stream(0, 0, "bp_drain");
        repeat (4) @(negedge clk);
        check("bp_after_valid", 32'(out_valid), 32'd0);
        check("bp_after_busy", 32'(busy), 32'd0);

        // Reset while the request sits in WAIT.
        in_valid = 1'b1; in_a = 16'h0F0F; in_amt = 5'd2; in_tag = 3'd6;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_state_wait", 32'(dbg_state), 32'd2);
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_sh_a", 32'(sh_a), 32'd0);
        check("mid_rst_sh_amt", 32'(sh_amt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mid_no_output", 32'(seen), 32'd0);
        check("mid_busy_after", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_feeder.md
SHIFT_FEEDER -- requirements
Module: shift_feeder

Interface
REQ-001 Parameter: SHIFT_LAT, 1, register stages inside the Shifter between its inputs (a, shiftAmt) and its output r.
REQ-002 Parameter: FIFO_DEPTH, 2, request buffer entries (power of two, minimum 2).
REQ-003 Ports, one per line, as name / direction / width / meaning:
- clk / in / 1 / single clock; all state updates on its rising edge.
- reset_n / in / 1 / reset, asynchronous, active-low.
- in_valid / in / 1 / shift request present.
- in_ready / out / 1 / request buffer can accept.
- in_a / in / 16 / operand.
- in_amt / in / 5 / two's-complement shift amount; positive = left, negative = logical right.
- in_tag / in / 3 / destination register tag.
- sh_a / out / 16 / operand to Shifter input a.
- sh_amt / out / 5 / amount to Shifter input shiftAmt.
- sh_r / in / 16 / Shifter result r.
- out_valid / out / 1 / result present.
- out_ready / in / 1 / consumer accepts result.
- out_r / out / 16 / result.
- out_tag / out / 3 / tag of result.
- busy / out / 1 / any request buffered or in flight.

Function
REQ-004 A request is accepted on a rising edge where in_valid=1 and in_ready=1; {in_a, in_amt, in_tag} is pushed into the FIFO.
REQ-005 in_ready SHALL be 1 iff the FIFO is not full; it SHALL have no combinational dependence on out_ready or in_valid.
REQ-006 Push while full is not accepted; the FIFO is unchanged and no error is raised.
REQ-007 Issue FSM states:
- IDLE: FIFO empty or awaiting issue.
- ISSUE: exactly 1 cycle; Shifter samples its inputs.
- WAIT: exactly SHIFT_LAT cycles.
- OUT: result held for the consumer.
REQ-008 Transitions:
- IDLE with FIFO nonempty -> ISSUE: pop the head; load sh_a, sh_amt and the in-flight tag.
- ISSUE -> WAIT.
- Last WAIT cycle -> OUT: register sh_r into out_r and the tag into out_tag; set out_valid=1.
- OUT with out_ready=1 -> ISSUE (popping the head) if the FIFO is nonempty, else IDLE.
- OUT with out_ready=0 -> stay in OUT; out_r, out_tag and out_valid held stable.
REQ-009 sh_a and sh_amt SHALL be registered and held constant from the issue edge through the end of WAIT.
REQ-010 Latency from the accept edge to out_valid rising (empty pipeline, no bypass) = 2+SHIFT_LAT cycles (3 at default).
REQ-011 A push and a pop on the same edge are both performed; the count is unchanged.
REQ-012 Results leave in acceptance order; out_tag always matches its request.
REQ-013 busy = (state != IDLE) OR (FIFO nonempty).
REQ-014 The block performs no arithmetic on data; out_r equals sh_r exactly as captured.

Reset
REQ-015 reset_n low asynchronously forces:
- state IDLE and FIFO empty;
- out_valid, out_r, out_tag, sh_a, sh_amt and busy to 0;
- in_ready to 0.
REQ-016 A reset asserted mid-operation discards all buffered and in-flight requests; no partial result is emitted after release.
REQ-017 After reset_n rises, in_ready SHALL be 1 on the first cycle.

Configuration
REQ-018 Macro SHIFT_ZERO_BYPASS_EN:
- Defined: a popped head with in_amt=0 skips ISSUE and WAIT; out_r <= operand, out_tag <= tag and out_valid=1 on the pop edge (latency 1 cycle from acceptance on an empty pipeline); sh_a and sh_amt are not updated.
- Undefined: zero amounts take the normal path, latency 2+SHIFT_LAT.

Verification
REQ-019 Push a=16'd128, amt=1, tag=3, out_ready=1 -> out_valid 3 cycles after accept with out_r=16'd256, out_tag=3.
REQ-020 Back-to-back pushes (100,4), (10000,-1), (10000,5'b11110) -> out_r sequence 1600, 5000, 2500 in order with tags preserved.
REQ-021 out_ready=0, push 4 requests -> first 3 accepted (1 in flight, 2 buffered), 4th sees in_ready=0; after out_ready=1 all 3 drain in order.
REQ-022 reset_n low during WAIT -> out_valid=0 and busy=0 immediately; no output after release; in_ready=1 on the first cycle after release.
REQ-023 Push a=16'h1234, amt=0 -> with SHIFT_ZERO_BYPASS_EN out_valid 1 cycle after accept and sh_a unchanged; without it, 3 cycles; out_r=16'h1234 in both.
REQ-024 Push and pop on the same edge with the FIFO holding 1 entry -> count stays 1; in_ready stays 1.
